// File: rtl/adc_capture_sequencer_if.sv
// Stream bundle between the ADC core, the capture sequencer and the DMA/FIFO sink.
//   tvalid : word valid
//   tready : sink ready (unused on the ADC side, the source cannot stall)
//   tdata  : 32-bit word, [31:30] tag (2'b10 data, 2'b11 last word of burst)
//   tlast  : last word of burst (driven on the sink side only)
interface adc_capture_sequencer_if;
    localparam int unsigned DATA_W = 32;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    // Producer side of the sink link
    modport master (output tvalid, output tdata, output tlast, input tready);
    // ADC side: no back-pressure, tag carried inside tdata
    modport slave  (input tvalid, input tdata);
endinterface

// File: rtl/adc_capture_sequencer.sv
// Sequences capture bursts on the ADC trigger/burst core and forwards its tagged
// stream to a back-pressured sink.
//   aclk, aresetn             : clock, asynchronous active-low reset
//   i_cfg_start / i_cfg_abort : one-cycle run control pulses
//   i_cfg_bursts/gap/timeout  : run configuration, latched on accepted start
//   o_adc_reset_trigger       : 0 holds the ADC trigger in reset / re-arm
//   o_adc_reset_max_sum       : 1 clears the ADC max-sum tracker
//   s_axis                    : ADC word stream (no ready)
//   m_axis                    : forwarded stream to the DMA/FIFO path
//   o_busy, o_done, o_timeout_err, o_overflow, o_bursts_done, o_words_fwd, o_state : status
module adc_capture_sequencer #(
    parameter int unsigned BURST_W = 16,
    parameter int unsigned TIMER_W = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    i_cfg_start,
    input  logic                    i_cfg_abort,
    input  logic [BURST_W-1:0]      i_cfg_bursts,
    input  logic [TIMER_W-1:0]      i_cfg_gap,
    input  logic [TIMER_W-1:0]      i_cfg_timeout,
    output logic                    o_adc_reset_trigger,
    output logic                    o_adc_reset_max_sum,
    adc_capture_sequencer_if.slave  s_axis,
    adc_capture_sequencer_if.master m_axis,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_timeout_err,
    output logic                    o_overflow,
    output logic [BURST_W-1:0]      o_bursts_done,
    output logic [TIMER_W-1:0]      o_words_fwd,
    output logic [2:0]              o_state
);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [TIMER_W-1:0]  r_timer;
    logic [BURST_W-1:0]  r_cfg_bursts;
    logic [TIMER_W-1:0]  r_cfg_gap;
    logic [TIMER_W-1:0]  r_cfg_timeout;
    logic                r_busy, r_done, r_trig, r_max_sum;
    logic                r_timeout_err, r_overflow;
    logic [BURST_W-1:0]  r_bursts_done;
    logic [TIMER_W-1:0]  r_words_fwd;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_last;

    logic                w_tag_last;
    logic                w_last_word;
    logic                w_timeout_hit;
    logic                w_fwd_en;
    logic                w_out_free;
    logic [BURST_W-1:0]  w_bursts_inc;
    logic [TIMER_W-1:0]  w_gap_end;

    assign w_tag_last   = (s_axis.tdata[31:30] == 2'b11);
    assign w_last_word  = s_axis.tvalid && w_tag_last;
    assign w_bursts_inc = (r_bursts_done == '1) ? r_bursts_done : r_bursts_done + BURST_W'(1);
    // A zero gap still needs one low cycle so the ADC core can re-arm
    assign w_gap_end    = (r_cfg_gap == '0) ? '0 : r_cfg_gap - TIMER_W'(1);
    assign w_fwd_en     = (r_state == ST_CAPTURE) || (r_state == ST_GAP) || (r_state == ST_DONE);
    assign w_out_free   = !r_m_valid || m_axis.tready;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cfg_start) w_state_nxt = (i_cfg_bursts != '0) ? ST_CLEAR : ST_DONE;
            end
            ST_CLEAR: w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (w_last_word) begin
                    w_state_nxt = (w_bursts_inc == r_cfg_bursts) ? ST_DONE : ST_GAP;
                end else if ((r_cfg_timeout != '0) && (r_timer == r_cfg_timeout)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_GAP: begin
                if (r_timer == w_gap_end) w_state_nxt = ST_CAPTURE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (i_cfg_abort && (r_state != ST_IDLE)) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_hit = 1'b0;
        end
    end

    // State-decoded controls, registered from the next state so they align with it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_trig    <= 1'b0;
            r_max_sum <= 1'b0;
        end else begin
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
            r_trig    <= (w_state_nxt == ST_CAPTURE);
            r_max_sum <= (w_state_nxt == ST_CLEAR);
        end
    end

    // Per-state timer: restarts on every state change, saturates
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                  r_timer <= '0;
        else if (w_state_nxt != r_state) r_timer <= '0;
        else if (r_timer != '1)        r_timer <= r_timer + TIMER_W'(1);
    end

    // Configuration latch on accepted start
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cfg_bursts  <= '0;
            r_cfg_gap     <= '0;
            r_cfg_timeout <= '0;
        end else if ((r_state == ST_IDLE) && i_cfg_start) begin
            r_cfg_bursts  <= i_cfg_bursts;
            r_cfg_gap     <= i_cfg_gap;
            r_cfg_timeout <= i_cfg_timeout;
        end
    end

    // Output register, run counters and sticky flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_last      <= 1'b0;
            r_words_fwd   <= '0;
            r_bursts_done <= '0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_last      <= 1'b0;
            r_words_fwd   <= '0;
            r_bursts_done <= '0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_m_valid && m_axis.tready) r_m_valid <= 1'b0;
            if (w_fwd_en && s_axis.tvalid) begin
                if (w_out_free) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= s_axis.tdata;
                    r_m_last  <= w_tag_last;
                    if (r_words_fwd != '1) r_words_fwd <= r_words_fwd + TIMER_W'(1);
                end else begin
                    r_overflow <= 1'b1;
                end
            end
            if ((r_state == ST_CAPTURE) && w_last_word) r_bursts_done <= w_bursts_inc;
            if (w_timeout_hit) r_timeout_err <= 1'b1;
        end
    end

    assign o_adc_reset_trigger = r_trig;
    assign o_adc_reset_max_sum = r_max_sum;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_timeout_err       = r_timeout_err;
    assign o_overflow          = r_overflow;
    assign o_bursts_done       = r_bursts_done;
    assign o_words_fwd         = r_words_fwd;
    assign o_state             = r_state;
    assign m_axis.tvalid       = r_m_valid;
    assign m_axis.tdata        = r_m_data;
    assign m_axis.tlast        = r_m_last;
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: burst runs, timeout, overflow,
// abort, zero-burst start and asynchronous reset mid-gap.
module tb_adc_capture_sequencer;
    localparam int unsigned BURST_W = 16;
    localparam int unsigned TIMER_W = 32;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic               cfg_start = 1'b0;
    logic               cfg_abort = 1'b0;
    logic [BURST_W-1:0] cfg_bursts = '0;
    logic [TIMER_W-1:0] cfg_gap = '0;
    logic [TIMER_W-1:0] cfg_timeout = '0;
    logic               adc_reset_trigger, adc_reset_max_sum;
    logic               busy, done, timeout_err, overflow;
    logic [BURST_W-1:0] bursts_done;
    logic [TIMER_W-1:0] words_fwd;
    logic [2:0]         state;

    adc_capture_sequencer_if s_axis ();
    adc_capture_sequencer_if m_axis ();

    always #5 aclk = ~aclk;

    adc_capture_sequencer #(.BURST_W(BURST_W), .TIMER_W(TIMER_W)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .i_cfg_start         (cfg_start),
        .i_cfg_abort         (cfg_abort),
        .i_cfg_bursts        (cfg_bursts),
        .i_cfg_gap           (cfg_gap),
        .i_cfg_timeout       (cfg_timeout),
        .o_adc_reset_trigger (adc_reset_trigger),
        .o_adc_reset_max_sum (adc_reset_max_sum),
        .s_axis              (s_axis.slave),
        .m_axis              (m_axis.master),
        .o_busy              (busy),
        .o_done              (done),
        .o_timeout_err       (timeout_err),
        .o_overflow          (overflow),
        .o_bursts_done       (bursts_done),
        .o_words_fwd         (words_fwd),
        .o_state             (state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sink-side monitor, sampled on the falling edge
    int          acc_words, acc_last, done_pulses, trig_highs, maxsum_highs, low_run;
    int          gap_q[$];
    bit          seen_high, prev_hold;
    logic [31:0] prev_data;

    always @(negedge aclk) begin
        if (m_axis.tvalid && m_axis.tready) begin
            acc_words++;
            if (m_axis.tlast) acc_last++;
            check("tlast_vs_tag", 32'(m_axis.tlast), 32'(m_axis.tdata[31:30] == 2'b11));
        end
        if (prev_hold) begin
            check("hold_valid", 32'(m_axis.tvalid), 1);
            check("hold_data", m_axis.tdata, prev_data);
        end
        prev_hold = m_axis.tvalid && !m_axis.tready;
        prev_data = m_axis.tdata;
        if (done) done_pulses++;
        if (adc_reset_max_sum) maxsum_highs++;
        if (adc_reset_trigger) begin
            trig_highs++;
            if (seen_high && low_run > 0) gap_q.push_back(low_run);
            seen_high = 1'b1;
            low_run   = 0;
        end else begin
            low_run++;
        end
    end

    task automatic clear_mon();
        acc_words = 0; acc_last = 0; done_pulses = 0; trig_highs = 0; maxsum_highs = 0;
        low_run = 0; seen_high = 1'b0; gap_q.delete();
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start(input int b, input int g, input int t);
        cfg_bursts  = BURST_W'(b);
        cfg_gap     = TIMER_W'(g);
        cfg_timeout = TIMER_W'(t);
        cfg_start   = 1'b1;
        tick();
        cfg_start   = 1'b0;
    endtask

    task automatic drive_word(input int i, input int n);
        logic [31:0] w;
        w = {(i == n - 1) ? 2'b11 : 2'b10, 30'(i)};
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = w;
        tick();
        s_axis.tvalid = 1'b0;
    endtask

    task automatic send_burst(input int n);
        for (int i = 0; i < n; i++) drive_word(i, n);
    endtask

    task automatic wait_trig(input string tag, input int limit);
        int k;
        k = 0;
        while (!adc_reset_trigger && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(adc_reset_trigger), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tready = 1'b0;
        m_axis.tready = 1'b1;
        clear_mon();
        repeat (3) tick();
        check("rst_state", 32'(state), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_trig", 32'(adc_reset_trigger), 0);
        check("rst_words", words_fwd, 0);
        check("rst_tvalid", 32'(m_axis.tvalid), 0);
        aresetn = 1'b1;
        tick();

        // Three 32-word bursts, gap 4, sink always ready
        clear_mon();
        start(3, 4, 0);
        check("t1_clear_state", 32'(state), 1);
        check("t1_clear_maxsum", 32'(adc_reset_max_sum), 1);
        check("t1_clear_trig", 32'(adc_reset_trigger), 0);
        tick();
        check("t1_cap_state", 32'(state), 2);
        check("t1_cap_trig", 32'(adc_reset_trigger), 1);
        for (int b = 0; b < 3; b++) begin
            wait_trig("t1_arm", 50);
            send_burst(32);
        end
        check("t1_done_state", 32'(state), 4);
        check("t1_done_pulse", 32'(done), 1);
        check("t1_done_trig", 32'(adc_reset_trigger), 0);
        check("t1_bursts", 32'(bursts_done), 3);
        tick();
        check("t1_idle_state", 32'(state), 0);
        check("t1_idle_done", 32'(done), 0);
        repeat (2) tick();
        check("t1_words_fwd", words_fwd, 96);
        check("t1_acc_words", acc_words, 96);
        check("t1_acc_last", acc_last, 3);
        check("t1_done_cnt", done_pulses, 1);
        check("t1_overflow", 32'(overflow), 0);
        check("t1_gap_count", gap_q.size(), 2);
        if (gap_q.size() == 2) begin
            check("t1_gap0", gap_q[0], 4);
            check("t1_gap1", gap_q[1], 4);
        end

        // Silent ADC, timeout 100
        clear_mon();
        start(1, 0, 100);
        tick();
        cnt = 0;
        while (state == 3'd2 && cnt < 1000) begin
            tick();
            cnt++;
        end
        check("t2_capture_len", cnt, 101);
        check("t2_state", 32'(state), 4);
        check("t2_done", 32'(done), 1);
        check("t2_timeout_err", 32'(timeout_err), 1);
        check("t2_bursts", 32'(bursts_done), 0);
        tick();
        check("t2_idle", 32'(state), 0);
        check("t2_done_cnt", done_pulses, 1);

        // Sink stalls for five words mid-burst
        clear_mon();
        start(1, 0, 0);
        tick();
        for (int i = 0; i < 32; i++) begin
            m_axis.tready = !(i >= 10 && i < 15);
            drive_word(i, 32);
        end
        m_axis.tready = 1'b1;
        check("t3_state", 32'(state), 4);
        repeat (3) tick();
        check("t3_overflow", 32'(overflow), 1);
        check("t3_words_fwd", words_fwd, 27);
        check("t3_acc_words", acc_words, 27);
        check("t3_acc_last", acc_last, 1);
        check("t3_bursts", 32'(bursts_done), 1);
        check("t3_timeout_err", 32'(timeout_err), 0);

        // Abort at capture cycle 10
        clear_mon();
        start(2, 0, 0);
        tick();
        repeat (9) tick();
        check("t4_pre_state", 32'(state), 2);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("t4_state", 32'(state), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_trig", 32'(adc_reset_trigger), 0);
        repeat (2) tick();
        check("t4_state_hold", 32'(state), 0);
        check("t4_no_done", done_pulses, 0);
        check("t4_overflow", 32'(overflow), 0);

        // Zero-burst start after the abort
        clear_mon();
        start(0, 5, 5);
        check("t5_state", 32'(state), 4);
        check("t5_done", 32'(done), 1);
        check("t5_trig", 32'(adc_reset_trigger), 0);
        tick();
        check("t5_idle", 32'(state), 0);
        repeat (2) tick();
        check("t5_trig_highs", trig_highs, 0);
        check("t5_maxsum_highs", maxsum_highs, 0);
        check("t5_done_cnt", done_pulses, 1);

        // Asynchronous reset during GAP, then a normal run
        clear_mon();
        start(2, 10, 0);
        tick();
        send_burst(4);
        repeat (3) tick();
        check("t6_pre_state", 32'(state), 3);
        check("t6_pre_bursts", 32'(bursts_done), 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_rst_state", 32'(state), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_bursts", 32'(bursts_done), 0);
        check("t6_rst_words", words_fwd, 0);
        check("t6_rst_tvalid", 32'(m_axis.tvalid), 0);
        tick();
        aresetn = 1'b1;
        tick();
        start(1, 0, 0);
        tick();
        send_burst(4);
        check("t6_run_state", 32'(state), 4);
        check("t6_run_done", 32'(done), 1);
        check("t6_run_bursts", 32'(bursts_done), 1);
        tick();
        check("t6_run_words", words_fwd, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
